// File: rtl/counter_pkg.sv
//==============================================================================
// Module   : counter_pkg
// Purpose  : Shared direction encoding and default geometry for the cascaded
//            up/down counter.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH  = 5;
    localparam int DEFAULT_DIGITS = 2;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/cascade_updown_counter_digit.sv
//==============================================================================
// Module   : counter_digit
// Purpose  : One wrapping up/down digit with run-time limit, clamped parallel
//            load and a combinational step_out toward the next digit.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module counter_digit
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MIN_VAL = 0,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] value,
    output logic             step_out
);

    localparam logic [WIDTH-1:0] c_min = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] c_rst = WIDTH'(RST_VAL);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_clamped;
    logic             w_limit_low;
    logic             w_at_top;
    logic             w_at_bottom;
    logic             w_above;

    assign w_limit_low = (limit < c_min);
    assign w_at_top    = (r_value >= limit);
    assign w_at_bottom = (r_value <= c_min);
    assign w_above     = (r_value > limit);

    // A digit whose limit sits below MIN_VAL is pinned and always terminal.
    assign step_out = step_in & (w_limit_low | ((dir == DIR_UP) ? w_at_top : w_at_bottom));
    assign value    = r_value;

    always_comb begin
        w_clamped = (load_value > limit) ? limit : load_value;
        if (w_clamped < c_min) begin
            w_clamped = c_min;
        end

        w_next = r_value;
        if (w_limit_low) begin
            w_next = c_min;
        end else if (load) begin
            w_next = w_clamped;
        end else if (step_in) begin
            if (dir == DIR_UP) begin
                w_next = w_at_top ? c_min : (r_value + c_one);
            end else if (w_above || w_at_bottom) begin
                // Above a lowered limit: snap to it without passing a borrow.
                w_next = limit;
            end else begin
                w_next = r_value - c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= c_rst;
        end else begin
            r_value <= w_next;
        end
    end

endmodule : counter_digit

`default_nettype wire

// File: rtl/cascade_updown_counter.sv
//==============================================================================
// Module   : cascade_updown_counter
// Purpose  : DIGITS cascaded up/down digits with single-cycle ripple, carry and
//            borrow pulses. Define CASCADE_COUNTER_SATURATE_EN to hold at the
//            end of range instead of wrapping.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module cascade_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int DIGITS  = DEFAULT_DIGITS,
    parameter int MIN_VAL = 0,
    parameter int RST_VAL = MIN_VAL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    load,
    input  logic [DIGITS*WIDTH-1:0] load_value,
    input  logic [DIGITS*WIDTH-1:0] limit,
    output logic [DIGITS*WIDTH-1:0] value,
    output logic                    carry,
    output logic                    borrow
);

    localparam logic [WIDTH-1:0] c_min = WIDTH'(MIN_VAL);

    logic [DIGITS:0]   w_step;
    logic [DIGITS-1:0] w_up_term;
    logic [DIGITS-1:0] w_down_term;
    logic              w_count;
    logic              w_terminal;
    logic              w_pulse;

    assign w_count    = en & ~load;
    assign w_terminal = w_count & ((dir == DIR_UP) ? (&w_up_term) : (&w_down_term));

`ifdef CASCADE_COUNTER_SATURATE_EN
    assign w_step[0] = w_count & ~w_terminal;
`else
    assign w_step[0] = w_count;
`endif

    // In saturating builds the ripple chain never reaches the end, so the
    // pulse comes from the direct terminal decode.
    assign w_pulse = w_step[DIGITS] | w_terminal;
    assign carry   = rst_n & w_pulse & (dir == DIR_UP);
    assign borrow  = rst_n & w_pulse & (dir == DIR_DOWN);

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign w_up_term[i]   = (value[i*WIDTH +: WIDTH] >= limit[i*WIDTH +: WIDTH]);
            assign w_down_term[i] = (value[i*WIDTH +: WIDTH] <= c_min);

            counter_digit #(
                .WIDTH   (WIDTH),
                .MIN_VAL (MIN_VAL),
                .RST_VAL (RST_VAL)
            ) u_digit (
                .clk        (clk),
                .rst_n      (rst_n),
                .step_in    (w_step[i]),
                .dir        (dir),
                .load       (load),
                .load_value (load_value[i*WIDTH +: WIDTH]),
                .limit      (limit[i*WIDTH +: WIDTH]),
                .value      (value[i*WIDTH +: WIDTH]),
                .step_out   (w_step[i+1])
            );
        end
    endgenerate

endmodule : cascade_updown_counter

`default_nettype wire

// File: tb/tb_cascade_updown_counter.sv
//==============================================================================
// Module   : tb_cascade_updown_counter
// Purpose  : Self-checking bench: directed vector table, hand sequences around
//            wrap and asynchronous reset, and randomized traffic vs. a model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cascade_updown_counter;

    localparam int WIDTH   = 5;
    localparam int DIGITS  = 2;
    localparam int MIN_VAL = 0;
    localparam int RST_VAL = 0;
    localparam int VW      = DIGITS * WIDTH;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          dir;
    logic          load;
    logic [VW-1:0] load_value;
    logic [VW-1:0] limit;
    logic [VW-1:0] value;
    logic          carry;
    logic          borrow;

    int n_checks;
    int n_fail;
    int m_d[DIGITS];

    typedef struct {
        logic          en;
        logic          dir;
        logic          load;
        logic [VW-1:0] lv;
        logic [VW-1:0] lim;
        logic [VW-1:0] ev;
        logic          ec;
        logic          eb;
    } vec_t;

    vec_t tbl[14];

    cascade_updown_counter #(
        .WIDTH   (WIDTH),
        .DIGITS  (DIGITS),
        .MIN_VAL (MIN_VAL),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .limit      (limit),
        .value      (value),
        .carry      (carry),
        .borrow     (borrow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [VW-1:0] dv(input int tens, input int ones);
        logic [WIDTH-1:0] t;
        logic [WIDTH-1:0] o;
        t = WIDTH'(tens);
        o = WIDTH'(ones);
        return {t, o};
    endfunction

    function automatic int dig(input logic [VW-1:0] v, input int i);
        return (int'(v) >> (i * WIDTH)) & ((1 << WIDTH) - 1);
    endfunction

    function automatic vec_t mk(input logic e, input logic d, input logic l,
                                input logic [VW-1:0] lv, input logic [VW-1:0] lim,
                                input logic [VW-1:0] ev, input logic ec, input logic eb);
        vec_t r;
        r.en = e; r.dir = d; r.load = l; r.lv = lv; r.lim = lim;
        r.ev = ev; r.ec = ec; r.eb = eb;
        return r;
    endfunction

    function automatic logic [VW-1:0] model_value();
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | (VW'(m_d[i]) << (i * WIDTH));
        end
        return r;
    endfunction

    function automatic logic model_all_up(input logic [VW-1:0] lim);
        for (int i = 0; i < DIGITS; i++) begin
            if (m_d[i] < dig(lim, i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic model_all_down();
        for (int i = 0; i < DIGITS; i++) begin
            if (m_d[i] > MIN_VAL) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Counting treated as +/-1 in a mixed-radix number whose digit ranges
    // are [MIN_VAL, limit]; a digit above a lowered limit absorbs a down step.
    task automatic model_update(input logic e, input logic d, input logic l,
                                input logic [VW-1:0] lv, input logic [VW-1:0] lim);
        logic go;
        logic hold;
        int   x;
        hold = 1'b0;
`ifdef CASCADE_COUNTER_SATURATE_EN
        hold = d ? model_all_up(lim) : model_all_down();
`endif
        if (l) begin
            for (int i = 0; i < DIGITS; i++) begin
                x = (dig(lv, i) < dig(lim, i)) ? dig(lv, i) : dig(lim, i);
                m_d[i] = (x < MIN_VAL) ? MIN_VAL : x;
            end
        end else if (e && !hold) begin
            go = 1'b1;
            for (int i = 0; i < DIGITS && go; i++) begin
                if (d) begin
                    if (m_d[i] >= dig(lim, i)) m_d[i] = MIN_VAL;
                    else begin m_d[i] = m_d[i] + 1; go = 1'b0; end
                end else begin
                    if (m_d[i] > dig(lim, i)) begin m_d[i] = dig(lim, i); go = 1'b0; end
                    else if (m_d[i] <= MIN_VAL) m_d[i] = dig(lim, i);
                    else begin m_d[i] = m_d[i] - 1; go = 1'b0; end
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic do_cycle(input logic e, input logic d, input logic l,
                            input logic [VW-1:0] lv, input logic [VW-1:0] lim,
                            input logic [VW-1:0] ev, input logic ec, input logic eb,
                            input string nm);
        en = e; dir = d; load = l; load_value = lv; limit = lim;
        #1;
        chk({nm, " carry"}, 32'(carry), 32'(ec));
        chk({nm, " borrow"}, 32'(borrow), 32'(eb));
        @(posedge clk);
        #1;
        chk({nm, " value"}, 32'(value), 32'(ev));
        @(negedge clk);
    endtask

    task automatic model_cycle(input logic e, input logic d, input logic l,
                               input logic [VW-1:0] lv, input logic [VW-1:0] lim,
                               input string nm);
        logic ec;
        logic eb;
        ec = e & d & ~l & model_all_up(lim);
        eb = e & ~d & ~l & model_all_down();
        model_update(e, d, l, lv, lim);
        do_cycle(e, d, l, lv, lim, model_value(), ec, eb, nm);
    endtask

    initial begin
        logic [VW-1:0] lim59;
        logic [VW-1:0] rl;
        logic          re;
        logic          rd;
        logic          rld;
        n_checks = 0;
        n_fail   = 0;
        lim59    = dv(5, 9);
        for (int i = 0; i < DIGITS; i++) m_d[i] = RST_VAL;

        tbl[0]  = mk(1, 0, 0, dv(0, 0),  lim59,    dv(5, 9), 0, 1);
        tbl[1]  = mk(1, 1, 0, dv(0, 0),  lim59,    dv(0, 0), 1, 0);
`ifdef CASCADE_COUNTER_SATURATE_EN
        tbl[0]  = mk(1, 0, 0, dv(0, 0),  lim59,    dv(0, 0), 0, 1);
        tbl[1]  = mk(1, 1, 0, dv(0, 0),  lim59,    dv(0, 1), 0, 0);
`endif
        tbl[2]  = mk(0, 1, 1, dv(2, 4),  lim59,    dv(2, 4), 0, 0);
        tbl[3]  = mk(1, 1, 1, dv(3, 7),  lim59,    dv(3, 7), 0, 0);
        tbl[4]  = mk(1, 1, 0, dv(0, 0),  lim59,    dv(3, 8), 0, 0);
        tbl[5]  = mk(1, 1, 0, dv(0, 0),  lim59,    dv(3, 9), 0, 0);
        tbl[6]  = mk(1, 1, 0, dv(0, 0),  lim59,    dv(4, 0), 0, 0);
        tbl[7]  = mk(1, 0, 0, dv(0, 0),  lim59,    dv(3, 9), 0, 0);
        tbl[8]  = mk(0, 1, 0, dv(0, 0),  lim59,    dv(3, 9), 0, 0);
        tbl[9]  = mk(0, 0, 1, dv(7, 12), lim59,    dv(5, 9), 0, 0);
        tbl[10] = mk(0, 0, 1, dv(5, 0),  lim59,    dv(5, 0), 0, 0);
        tbl[11] = mk(1, 0, 0, dv(0, 0),  dv(3, 9), dv(3, 9), 0, 0);
        tbl[12] = mk(0, 0, 1, dv(0, 0),  lim59,    dv(0, 0), 0, 0);
        tbl[13] = mk(0, 0, 0, dv(0, 0),  lim59,    dv(0, 0), 0, 0);

        // Reset with a borrow-qualifying input pattern: outputs must stay low.
        rst_n = 1'b0; en = 1'b1; dir = 1'b0; load = 1'b0;
        load_value = '0; limit = lim59;
        #3;
        chk("reset value", 32'(value), 32'(dv(RST_VAL, RST_VAL)));
        chk("reset borrow", 32'(borrow), 32'd0);
        chk("reset carry", 32'(carry), 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 59; i++) model_cycle(1, 1, 0, '0, lim59, "up59");
        chk("reach 5:9", 32'(value), 32'(dv(5, 9)));
        model_cycle(1, 1, 0, '0, lim59, "wrap");
        model_cycle(1, 1, 0, '0, lim59, "post wrap");
`ifdef CASCADE_COUNTER_SATURATE_EN
        chk("saturate hold", 32'(value), 32'(dv(5, 9)));
`endif

        model_cycle(0, 0, 1, dv(0, 0), lim59, "preload");
        for (int i = 0; i < 14; i++) begin
            model_update(tbl[i].en, tbl[i].dir, tbl[i].load, tbl[i].lv, tbl[i].lim);
            do_cycle(tbl[i].en, tbl[i].dir, tbl[i].load, tbl[i].lv, tbl[i].lim,
                     tbl[i].ev, tbl[i].ec, tbl[i].eb, $sformatf("vec%0d", i));
        end

        // Asynchronous reset pulse between edges while counting from 4:2.
        model_cycle(0, 0, 1, dv(4, 2), lim59, "load 4:2");
        en = 1'b1; dir = 1'b1; load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset value", 32'(value), 32'(dv(RST_VAL, RST_VAL)));
        chk("async reset carry", 32'(carry), 32'd0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < DIGITS; i++) m_d[i] = RST_VAL;
        model_update(1, 1, 0, '0, lim59);
        @(posedge clk);
        #1;
        chk("first step after reset", 32'(value), 32'(model_value()));
        @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            re  = ($urandom_range(0, 9) < 8);
            rd  = 1'($urandom_range(0, 1));
            rld = ($urandom_range(0, 15) == 0);
            rl  = ($urandom_range(0, 7) == 0) ? VW'($urandom) : lim59;
            model_cycle(re, rd, rld, VW'($urandom), rl, $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cascade_updown_counter

`default_nettype wire
